// File: rtl/qkv_proj.sv
// -----------------------------------------------------------------------------
// qkv_proj
//   Projects a token matrix X (DIM x EMB) through three weight matrices to
//   produce Q = X*Wq, K = X*Wk and V = X*Wv (each DIM x HID). There are three
//   signed fixed-point MACs, one per projection, and they run in lockstep. Each
//   MAC does one product per cycle. Each finished element is floored by FRAC
//   bits and then saturated to D_W bits. The three result matrices are
//   published together with a one-cycle O_VLD pulse.
//
// Ports
//   I_CLK     clock, rising edge
//   I_RST_N   asynchronous active-low reset
//   I_START   start request, honoured only while idle
//   I_MAT_X   X,  element (r,c) at [(r*EMB+c)*D_W +: D_W]
//   I_W_Q/K/V weights, element (r,c) at [(r*HID+c)*D_W +: D_W]
//   O_BUSY    high while a projection is in progress
//   O_VLD     one-cycle completion pulse
//   O_MAT_Q/K/V results, element (r,c) at [(r*HID+c)*D_W +: D_W]
// -----------------------------------------------------------------------------
module qkv_proj #(
  parameter int D_W  = 16,
  parameter int FRAC = 8,
  parameter int DIM  = 4,
  parameter int EMB  = 4,
  parameter int HID  = 3
) (
  input  logic                   I_CLK,
  input  logic                   I_RST_N,
  input  logic                   I_START,
  input  logic [DIM*EMB*D_W-1:0] I_MAT_X,
  input  logic [EMB*HID*D_W-1:0] I_W_Q,
  input  logic [EMB*HID*D_W-1:0] I_W_K,
  input  logic [EMB*HID*D_W-1:0] I_W_V,
  output logic                   O_BUSY,
  output logic                   O_VLD,
  output logic [DIM*HID*D_W-1:0] O_MAT_Q,
  output logic [DIM*HID*D_W-1:0] O_MAT_K,
  output logic [DIM*HID*D_W-1:0] O_MAT_V
);

  localparam int NMAC  = 3;                       // Q, K, V
  localparam int PW    = 2 * D_W;                 // full product width
  localparam int ACC_W = PW + $clog2(EMB);        // EMB products summed, cannot overflow
  localparam int RW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int CW    = (HID > 1) ? $clog2(HID) : 1;
  localparam int KW    = (EMB > 1) ? $clog2(EMB) : 1;
  localparam int XW    = DIM * EMB * D_W;
  localparam int WW    = EMB * HID * D_W;
  localparam int OW    = DIM * HID * D_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {S_IDLE, S_CALC} state_e;

  // Floor (arithmetic shift) then clamp to the signed D_W range.
  function automatic logic [D_W-1:0] round_sat(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    sh = s >>> FRAC;
    if (sh > SAT_MAX)      round_sat = SAT_MAX[D_W-1:0];
    else if (sh < SAT_MIN) round_sat = SAT_MIN[D_W-1:0];
    else                   round_sat = sh[D_W-1:0];
  endfunction

  state_e                  state_q, state_d;
  logic [RW-1:0]           r_q, r_d;
  logic [CW-1:0]           c_q, c_d;
  logic [KW-1:0]           k_q, k_d;
  logic [XW-1:0]           x_q;
  logic [WW-1:0]           w_q    [NMAC];
  logic signed [ACC_W-1:0] acc_q  [NMAC];
  logic signed [ACC_W-1:0] acc_d  [NMAC];
  logic [OW-1:0]           work_q [NMAC];
  logic [OW-1:0]           work_d [NMAC];
  logic [OW-1:0]           out_q  [NMAC];
  logic                    vld_q;
  logic                    load;
  logic                    done;

  // Datapath: the current X element is shared by the three MACs.
  int                      x_idx, w_idx, o_idx;
  logic signed [D_W-1:0]   x_e;
  logic signed [D_W-1:0]   w_e  [NMAC];
  logic signed [PW-1:0]    prod [NMAC];
  logic signed [ACC_W-1:0] sum  [NMAC];

  always_comb begin
    x_idx = (int'(r_q) * EMB + int'(k_q)) * D_W;
    w_idx = (int'(k_q) * HID + int'(c_q)) * D_W;
    o_idx = (int'(r_q) * HID + int'(c_q)) * D_W;
    x_e   = x_q[x_idx +: D_W];
    for (int m = 0; m < NMAC; m++) begin
      w_e[m]  = w_q[m][w_idx +: D_W];
      prod[m] = PW'(x_e) * PW'(w_e[m]);
      sum[m]  = acc_q[m] + ACC_W'(prod[m]);
    end
  end

  // Control: k steps fastest, then c, then r.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    load    = 1'b0;
    done    = 1'b0;
    for (int m = 0; m < NMAC; m++) begin
      acc_d[m]  = acc_q[m];
      work_d[m] = work_q[m];
    end

    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d = S_CALC;
          load    = 1'b1;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          for (int m = 0; m < NMAC; m++) acc_d[m] = '0;
        end
      end
      S_CALC: begin
        if (k_q == KW'(EMB - 1)) begin
          // The last product of an element goes straight into the result.
          // It never lands in the accumulator.
          k_d = '0;
          for (int m = 0; m < NMAC; m++) begin
            work_d[m][o_idx +: D_W] = round_sat(sum[m]);
            acc_d[m]                = '0;
          end
          if (c_q == CW'(HID - 1)) begin
            c_d = '0;
            if (r_q == RW'(DIM - 1)) begin
              r_d     = '0;
              done    = 1'b1;
              state_d = S_IDLE;
            end else begin
              r_d = r_q + RW'(1);
            end
          end else begin
            c_d = c_q + CW'(1);
          end
        end else begin
          k_d = k_q + KW'(1);
          for (int m = 0; m < NMAC; m++) acc_d[m] = sum[m];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      x_q     <= '0;
      vld_q   <= 1'b0;
      // NOTE: the register arrays are reset too. Aborted runs must leave clean state and zeroed outputs.
      for (int m = 0; m < NMAC; m++) begin
        w_q[m]    <= '0;
        acc_q[m]  <= '0;
        work_q[m] <= '0;
        out_q[m]  <= '0;
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      vld_q   <= done;
      if (load) begin
        x_q    <= I_MAT_X;
        w_q[0] <= I_W_Q;
        w_q[1] <= I_W_K;
        w_q[2] <= I_W_V;
      end
      for (int m = 0; m < NMAC; m++) begin
        acc_q[m]  <= acc_d[m];
        work_q[m] <= work_d[m];
        if (done) out_q[m] <= work_d[m];  // includes the final element
      end
    end
  end

  assign O_BUSY  = (state_q == S_CALC);
  assign O_VLD   = vld_q;
  assign O_MAT_Q = out_q[0];
  assign O_MAT_K = out_q[1];
  assign O_MAT_V = out_q[2];

endmodule

// File: tb/tb_qkv_proj.sv
// -----------------------------------------------------------------------------
// tb_qkv_proj
//   Directed bench for qkv_proj at its default parameters. When the bench
//   drives a start, a behavioural model computes the expected Q/K/V. Each
//   expected result is queued and then compared when O_VLD fires. Latency,
//   pulse width, busy, hold, ignored starts, reset abort and back-to-back
//   restarts are checked directly.
// -----------------------------------------------------------------------------
module tb_qkv_proj;

  localparam int D_W = 16;
  localparam int FRAC = 8;
  localparam int DIM = 4;
  localparam int EMB = 4;
  localparam int HID = 3;
  localparam int N_STEPS = DIM * EMB * HID;
  localparam int XW = DIM * EMB * D_W;
  localparam int WW = EMB * HID * D_W;
  localparam int OW = DIM * HID * D_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x = '0;
  logic [WW-1:0] wq = '0, wk = '0, wv = '0;
  logic          busy, vld;
  logic [OW-1:0] mq, mk, mv;

  qkv_proj #(.D_W(D_W), .FRAC(FRAC), .DIM(DIM), .EMB(EMB), .HID(HID)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .I_START (start),
    .I_MAT_X (x),
    .I_W_Q   (wq),
    .I_W_K   (wk),
    .I_W_V   (wv),
    .O_BUSY  (busy),
    .O_VLD   (vld),
    .O_MAT_Q (mq),
    .O_MAT_K (mk),
    .O_MAT_V (mv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] q;
    logic [OW-1:0] k;
    logic [OW-1:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   start_cyc = 0;
  int   vld_cyc = 0;
  int   prev_vld_cyc = 0;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [WW-1:0] fill_w(input logic [D_W-1:0] v);
    fill_w = {(EMB*HID){v}};
  endfunction

  function automatic logic [XW-1:0] fill_x(input logic [D_W-1:0] v);
    fill_x = {(DIM*EMB){v}};
  endfunction

  function automatic logic [OW-1:0] fill_o(input logic [D_W-1:0] v);
    fill_o = {(DIM*HID){v}};
  endfunction

  // Reference matrix product with floor and saturation, done in 64-bit integers.
  function automatic logic [OW-1:0] model(input logic [XW-1:0] xm, input logic [WW-1:0] wm);
    longint s;
    logic [OW-1:0] res;
    res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < HID; c++) begin
        s = 0;
        for (int k = 0; k < EMB; k++) begin
          s += longint'($signed(xm[(r*EMB+k)*D_W +: D_W])) *
               longint'($signed(wm[(k*HID+c)*D_W +: D_W]));
        end
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        res[(r*HID+c)*D_W +: D_W] = s[D_W-1:0];
      end
    end
    return res;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.q = model(x, wq);
    e.k = model(x, wk);
    e.v = model(x, wv);
    sb.push_back(e);
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    push_exp();
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  // Waits a bounded number of cycles for O_VLD, then checks latency and the scoreboard.
  task automatic wait_vld(input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vld === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, " vld_seen"}, OW'(seen), OW'(1));
    if (seen) begin
      vld_cyc = cyc;
      check({tag, " latency"}, OW'(cyc - start_cyc), OW'(N_STEPS));
      check({tag, " busy_low_at_vld"}, OW'(busy), OW'(0));
      check({tag, " sb_nonempty"}, OW'(sb.size() > 0), OW'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, " Q"}, mq, e.q);
        check({tag, " K"}, mk, e.k);
        check({tag, " V"}, mv, e.v);
      end
    end
  endtask

  initial begin
    int extra;

    // Reset state
    #12;
    check("reset busy", OW'(busy), OW'(0));
    check("reset vld", OW'(vld), OW'(0));
    check("reset Q", mq, '0);
    check("reset K", mk, '0);
    check("reset V", mv, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: uniform values, check exact latency and a one-cycle pulse
    x = fill_x(16'h0100); wq = fill_w(16'h0080); wk = fill_w(16'h0080); wv = fill_w(16'h0080);
    start_run();
    check("t1 busy_high", OW'(busy), OW'(1));
    wait_vld("t1");
    check("t1 Q const", mq, fill_o(16'h0200));
    check("t1 V const", mv, fill_o(16'h0200));
    @(negedge clk);
    check("t1 vld_one_cycle", OW'(vld), OW'(0));

    // 2: saturation at both rails
    x = fill_x(16'h7FFF); wq = fill_w(16'h7FFF); wk = fill_w(16'h8000); wv = fill_w(16'h7FFF);
    start_run();
    wait_vld("t2");
    check("t2 Q rail_hi", mq, fill_o(16'h7FFF));
    check("t2 K rail_lo", mk, fill_o(16'h8000));

    // 3: floor rounding of a single small product
    x = '0; x[15:0] = 16'h0001;
    wq = '0; wq[15:0] = 16'h0080;
    wk = '0; wk[15:0] = 16'hFF80;
    wv = '0; wv[15:0] = 16'h7FFF;
    start_run();
    wait_vld("t3");
    check("t3 Q00 floor", OW'(mq[15:0]), OW'(16'h0000));
    check("t3 K00 floor", OW'(mk[15:0]), OW'(16'hFFFF));
    check("t3 K others", OW'(mk[OW-1:16]), OW'(0));

    // 4: outputs hold during a run, and a start while busy is ignored
    x = fill_x(16'h0100); wq = fill_w(16'h0080); wk = fill_w(16'h0080); wv = fill_w(16'h0080);
    start_run();
    wait_vld("t4 run1");
    x = '0;
    start_run();
    repeat (8) @(negedge clk);
    @(negedge clk);
    x = fill_x(16'h0100);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x = '0;
    @(negedge clk);
    check("t4 hold Q", mq, fill_o(16'h0200));
    check("t4 busy mid", OW'(busy), OW'(1));
    wait_vld("t4 run2");
    check("t4 run2 Q zero", mq, '0);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (vld === 1'b1) extra++;
    end
    check("t4 no queued run", OW'(extra), OW'(0));

    // 5: reset in the middle of a run aborts it immediately
    x = fill_x(16'h0100); wq = fill_w(16'h0080); wk = fill_w(16'h0080); wv = fill_w(16'h0080);
    start_run();
    wait_vld("t5 pre");
    start_run();
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 rst Q", mq, '0);
    check("t5 rst K", mk, '0);
    check("t5 rst V", mv, '0);
    check("t5 rst busy", OW'(busy), OW'(0));
    check("t5 rst vld", OW'(vld), OW'(0));
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    x = fill_x(16'h7FFF); wq = fill_w(16'h7FFF); wk = fill_w(16'h8000); wv = fill_w(16'h0100);
    start_run();
    wait_vld("t5 fresh");

    // 6: start held high restarts in every O_VLD cycle; the weights are random
    for (int i = 0; i < EMB*HID; i++) begin
      wq[i*D_W +: D_W] = D_W'($urandom_range(0, 1023)) - 16'd512;
      wk[i*D_W +: D_W] = D_W'($urandom_range(0, 1023)) - 16'd512;
      wv[i*D_W +: D_W] = D_W'($urandom_range(0, 1023)) - 16'd512;
    end
    @(negedge clk);
    x = fill_x(16'h0100);
    start = 1'b1;
    push_exp();
    @(posedge clk);
    #1;
    start_cyc = cyc;
    x = fill_x(16'hFFC0);
    wait_vld("t6 run1");
    prev_vld_cyc = vld_cyc;
    push_exp();
    @(posedge clk);
    #1;
    start_cyc = cyc;
    for (int i = 0; i < DIM*EMB; i++) x[i*D_W +: D_W] = D_W'(i * 64 - 300);
    wait_vld("t6 run2");
    check("t6 period2", OW'(vld_cyc - prev_vld_cyc), OW'(N_STEPS + 1));
    prev_vld_cyc = vld_cyc;
    push_exp();
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    wait_vld("t6 run3");
    check("t6 period3", OW'(vld_cyc - prev_vld_cyc), OW'(N_STEPS + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
